// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1..2 stop bits, one bit per tx_clk.
// A one-word holding register lets a queued word follow the final stop bit with no idle gap.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module uart_tx #(
   parameter int DATA_WIDTH = `DATA_WIDTH,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                  tx_clk,
   input  logic                  tx_rst_n,
   input  logic                  tx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_ready,
   output logic                  tx_out,
   output logic                  tx_busy,
   output logic                  tx_done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

   // Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
   // tx_ready depends only on the holding register, never on tx_valid.
   logic [2:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
   logic                  par_q, par_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic                  stop_cnt_q, stop_cnt_d;

   logic                  accept;
   logic                  load;
   logic                  stop_last;
   logic [DATA_WIDTH-1:0] load_word;

   assign accept    = tx_valid && !hold_full_q;
   assign stop_last = (STOP_BITS == 1) || stop_cnt_q;
   assign load_word = hold_full_q ? hold_q : tx_data;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      par_d       = par_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      load        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (hold_full_q || accept) begin
               load = 1'b1;
            end
         end
         S_START: begin
            state_d   = S_DATA;
            bit_cnt_d = 4'd0;
         end
         S_DATA: begin
            shift_d = shift_q >> 1;
            if (bit_cnt_q == LAST_BIT) begin
               state_d    = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               stop_cnt_d = 1'b0;
            end else begin
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
         end
         S_PARITY: begin
            state_d    = S_STOP;
            stop_cnt_d = 1'b0;
         end
         S_STOP: begin
            if (stop_last) begin
               if (hold_full_q) begin
                  load = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               stop_cnt_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Parity comes from the word as loaded, since the shifter is consumed bit by bit.
      if (load) begin
         shift_d = load_word;
         par_d   = (^load_word) ^ 1'(PARITY_ODD);
         state_d = S_START;
         if (hold_full_q) begin
            hold_full_d = 1'b0;
         end
      end

      // A word accepted in IDLE goes straight into the shifter and bypasses the holding register.
      if (accept && !(load && !hold_full_q)) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge tx_clk or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         par_q       <= 1'b0;
         bit_cnt_q   <= 4'd0;
         stop_cnt_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         par_q       <= par_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
      end
   end

   always_comb begin
      case (state_q)
         S_START:  tx_out = 1'b0;
         S_DATA:   tx_out = shift_q[0];
         S_PARITY: tx_out = par_q;
         default:  tx_out = 1'b1;
      endcase
   end

   assign tx_ready = !hold_full_q;
   assign tx_busy  = (state_q != S_IDLE);
   assign tx_done  = (state_q == S_STOP) && stop_last;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations share one stimulus stream and are each compared
// every cycle against a frame-queue model of the serial line and holding register.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid;
   logic [7:0] data;
   logic [2:0] rdy_w, out_w, busy_w, done_w;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   uart_tx u0 (
      .tx_clk(clk), .tx_rst_n(rst_n), .tx_valid(valid), .tx_data(data),
      .tx_ready(rdy_w[0]), .tx_out(out_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
   );
   uart_tx #(.PARITY_ODD(1)) u1 (
      .tx_clk(clk), .tx_rst_n(rst_n), .tx_valid(valid), .tx_data(data),
      .tx_ready(rdy_w[1]), .tx_out(out_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
   );
   uart_tx #(.PARITY_EN(0), .STOP_BITS(2)) u2 (
      .tx_clk(clk), .tx_rst_n(rst_n), .tx_valid(valid), .tx_data(data),
      .tx_ready(rdy_w[2]), .tx_out(out_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
   );

   // Reference: remaining line bits of the current frame (bit 0 is on the wire now) plus the held word.
   int          cfg_pen[3]  = '{1, 1, 0};
   int          cfg_podd[3] = '{0, 1, 0};
   int          cfg_sb[3]   = '{1, 1, 2};
   logic [31:0] m_bits[3];
   int          m_len[3];
   logic        m_hv[3];
   logic [7:0]  m_hold[3];

   task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s u%0d: got=%0h exp=%0h at %0t", tag, i, got, exp, $time);
      end
   endtask

   task automatic load_frame(input int i, input logic [7:0] w);
      m_bits[i]    = '1;
      m_bits[i][0] = 1'b0;
      for (int k = 0; k < 8; k++) m_bits[i][1+k] = w[k];
      if (cfg_pen[i] != 0) m_bits[i][9] = (^w) ^ (cfg_podd[i] != 0);
      m_len[i] = 1 + 8 + cfg_pen[i] + cfg_sb[i];
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_bits[i] = '0;
         m_len[i]  = 0;
         m_hv[i]   = 1'b0;
         m_hold[i] = '0;
      end
   endtask

   task automatic model_edge();
      logic acc, taken;
      for (int i = 0; i < 3; i++) begin
         acc   = valid && !m_hv[i];
         taken = 1'b0;
         if (m_len[i] > 0) begin
            m_bits[i] = m_bits[i] >> 1;
            m_len[i]--;
            if (m_len[i] == 0 && m_hv[i]) begin
               load_frame(i, m_hold[i]);
               m_hv[i] = 1'b0;
            end
         end else if (m_hv[i]) begin
            load_frame(i, m_hold[i]);
            m_hv[i] = 1'b0;
         end else if (acc) begin
            load_frame(i, data);
            taken = 1'b1;
         end
         if (acc && !taken) begin
            m_hold[i] = data;
            m_hv[i]   = 1'b1;
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         chk("tx_out",   i, 32'(out_w[i]),  32'((m_len[i] > 0) ? m_bits[i][0] : 1'b1));
         chk("tx_busy",  i, 32'(busy_w[i]), 32'(m_len[i] > 0));
         chk("tx_done",  i, 32'(done_w[i]), 32'(m_len[i] == 1));
         chk("tx_ready", i, 32'(rdy_w[i]),  32'(!m_hv[i]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge();
      else model_reset();
      @(negedge clk);
      check_all();
   endtask

   task automatic send(input logic [7:0] w, input int wait_cycles);
      valid = 1'b1;
      data  = w;
      step();
      valid = 1'b0;
      repeat (wait_cycles) step();
   endtask

   logic [10:0] seq;

   initial begin
      rst_n = 1'b0;
      valid = 1'b0;
      data  = '0;
      model_reset();
      #1;
      check_all();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();

      // Default frame of 0xA5, recorded from the start-bit cycle onward.
      valid = 1'b1;
      data  = 8'hA5;
      step();
      valid = 1'b0;
      for (int k = 0; k < 11; k++) begin
         seq[k] = out_w[0];
         step();
      end
      chk("a5_seq", 0, 32'(seq), 32'(11'b10101001010));
      repeat (3) step();

      // Odd/even parity on all-zero and single-one words.
      send(8'h00, 14);
      send(8'h01, 14);

      // Back-to-back: the second word lands in the holding register.
      valid = 1'b1;
      data  = 8'h55;
      step();
      data  = 8'h0F;
      step();
      valid = 1'b0;
      repeat (26) step();

      // All ones: exercises the two-stop-bit configuration.
      send(8'hFF, 14);

      // Reset during data bit 3 with a second word held.
      valid = 1'b1;
      data  = 8'h3C;
      step();
      data  = 8'h81;
      step();
      valid = 1'b0;
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_out",   i, 32'(out_w[i]),  32'd1);
         chk("rst_ready", i, 32'(rdy_w[i]),  32'd1);
         chk("rst_busy",  i, 32'(busy_w[i]), 32'd0);
      end
      model_reset();
      step();
      step();
      rst_n = 1'b1;
      repeat (20) step();

      // Random traffic; tx_data changes every cycle, including while tx_ready is low.
      for (int c = 0; c < 3000; c++) begin
         valid = ($urandom_range(0, 3) != 0);
         data  = 8'($urandom);
         step();
      end
      valid = 1'b0;
      repeat (40) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
